seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Multiplexed 8-digit seven-segment display driver downstream of the CPU core.
- Consumes a 32-bit display word the CPU posts through a load strobe.
- Drives active-low SEG/AN pins on the board, refreshing one digit per slot.
- Includes anti-tearing double buffering, anti-ghosting guard blanking and optional leading-zero blanking.

Parameters:
- CLK_DIV, 100000: clk cycles per digit slot; must be ≥ 2.
- GUARD, 2: cycles at the start of each slot with all anodes off; must be < CLK_DIV.
- DIGITS, 8: digit count; fixed at 8 in this revision.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- load  in  1  single-cycle strobe; captures data and dp_mask into the pending buffer
- data  in  32  display word; nibble k is shown on digit k (digit 0 rightmost)
- dp_mask  in  8  decimal-point enable per digit, 1 = lit
- blank_en  in  1  level; 1 = blank leading zero digits
- committed  out  1  one-cycle pulse when the pending buffer is copied to the display buffer
- frame  out  1  one-cycle pulse on the last cycle of digit 7's slot
- SEG  out  8  active-low; SEG[7]=dp, SEG[6:0]=g..a
- AN  out  8  active-low anode select; at most one bit low

Behaviour:
- Reset (rst low, asynchronous) clears:
  - SEG=8'hFF, AN=8'hFF
  - display buffer and pending buffer to 0; dp regs to 0; pending_valid=0
  - idx=0, prescaler=0
  - committed=0, frame=0
- Prescaler:
  - counts 0..CLK_DIV-1, then wraps to 0.
  - tick = (prescaler==CLK_DIV-1).
  - On tick, idx increments mod 8.
- Frame end = tick && idx==7. On frame end:
  - frame=1 for that cycle.
  - If pending_valid, the display buffer takes the pending buffer, pending_valid clears, and committed=1 in the next cycle.
- load:
  - load=1 writes the pending buffer and sets pending_valid; any uncommitted value is overwritten (last write wins).
  - load on the same cycle as frame end: the commit uses the old pending value, and the new value stays pending for the next frame (no loss).
- Output registers:
  - SEG and AN are registered from (idx, prescaler, display buffer); one-cycle latency.
  - If prescaler < GUARD: AN=8'hFF and SEG=8'hFF.
  - Otherwise: AN = ~(1<<idx), SEG = {~dp[idx], font(nibble idx)}.
- Blanking:
  - With blank_en=1, digit k>0 is blanked (SEG=8'hFF, AN still asserted) when nibbles k..7 are all zero. dp of a blanked digit is also off.
  - Digit 0 is never blanked.
  - blank_en is sampled continuously and takes effect within one cycle.
- Font, as SEG[6:0] active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Display refresh period = 8*CLK_DIV cycles.
- Reset mid-slot returns to the reset state immediately. After release:
  - first slot is digit 0.
  - the first visible digit appears GUARD+1 cycles after release.

Decomposition:
- Package seg_pkg:
  - DIGITS constant
  - 16-entry font constant array
  - SEG_OFF=8'hFF and AN_OFF=8'hFF constants
- Sub-module hex_to_seg: combinational nibble → 7-bit active-low font lookup; instantiated once on the selected nibble.
- Everything else (prescaler, idx, buffers, output registers) lives in seg_scan_driver.

Test Plan (CLK_DIV=4, GUARD=1 for simulation):
1. Reset, then release. AN=FF and SEG=FF during reset. Cycle 1 after release: AN=FF (guard). Cycle 2: AN=FE, SEG=C0 (digit 0 showing '0').
2. load data=32'h89ABCDEF, dp_mask=8'h01, blank_en=0. No change until the next frame pulse; committed pulses one cycle after it. Then:
   - digit 0: AN=FE, SEG=0E (F with dp lit)
   - digit 1: AN=FD, SEG=A1 (d)
   - digit 7: AN=7F, SEG=80 (8)
3. Two loads within one frame (32'h1, then 32'h2). Only 32'h2 is ever displayed; exactly one committed pulse.
4. load asserted on the frame-end cycle with 32'h5. The previous pending value commits this frame; 32'h5 commits on the following frame; two committed pulses 32 cycles apart.
5. data=32'h00000105, blank_en=1:
   - digits 0..2 show 5,0,1 (SEG 92, C0, F9)
   - digits 3..7 show SEG=FF with AN still cycling
   - blank_en=0 → digit 3 shows C0 within one cycle
6. Assert rst mid-slot on digit 5. AN=FF and SEG=FF immediately (asynchronous). After release: digit 0 slot, display buffer=0, no committed pulse.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the seven-segment scan driver: digit count, the
// active-low hex font (SEG[6:0] = g..a) and the all-off pin patterns.
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int DIGITS = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Index is the nibble value; a 0 bit lights the segment.
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Combinational nibble to active-low seven-segment pattern.
// Ports:
//   i_nib  in  4  hex value
//   o_seg  out 7  active-low segments, bit 6 = g ... bit 0 = a
// -----------------------------------------------------------------------------
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = FONT[i_nib];

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Multiplexed 8-digit seven-segment driver. The CPU posts a 32-bit word into a
// pending buffer; it is copied to the display buffer only at frame end so a
// frame never shows a mix of old and new digits. Each digit slot starts with
// GUARD cycles of all anodes off to avoid ghosting, and leading zero digits can
// optionally be blanked.
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous active-low reset
//   load       in   1  strobe; captures data/dp_mask into the pending buffer
//   data       in  32  display word, nibble k on digit k (digit 0 rightmost)
//   dp_mask    in   8  decimal point per digit, 1 = lit
//   blank_en   in   1  1 = blank leading zero digits
//   committed  out  1  pulse the cycle after pending is copied to display
//   frame      out  1  pulse on the last cycle of digit 7's slot
//   SEG        out  8  active-low, SEG[7] = dp, SEG[6:0] = g..a
//   AN         out  8  active-low anode select, at most one bit low
// -----------------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int GUARD   = 2,
  parameter int DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic        blank_en,
  output logic        committed,
  output logic        frame,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GUARD_V = PW'(GUARD);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be at least 2");
  end
  if (GUARD >= CLK_DIV) begin : g_bad_guard
    $error("GUARD must be smaller than CLK_DIV");
  end
  if (DIGITS != seg_pkg::DIGITS) begin : g_bad_digits
    $error("only 8 digits are supported");
  end

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [31:0]   r_disp;
  logic [31:0]   r_pend;
  logic [7:0]    r_disp_dp;
  logic [7:0]    r_pend_dp;
  logic          r_pend_vld;
  logic          r_committed;
  logic [7:0]    r_seg;
  logic [7:0]    r_an;

  logic          w_tick;
  logic          w_frame_end;
  logic [3:0]    w_nib;
  logic [6:0]    w_font;
  logic [7:0]    w_zero_from;
  logic          w_blank;
  logic [7:0]    w_seg_nxt;
  logic [7:0]    w_an_nxt;

  assign w_tick      = (r_presc == PRE_MAX);
  assign w_frame_end = w_tick && (r_idx == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A load on the frame-end cycle must not be lost: the commit takes the old
  // pending value, and the load re-arms pending_valid afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp      <= '0;
      r_disp_dp   <= '0;
      r_pend      <= '0;
      r_pend_dp   <= '0;
      r_pend_vld  <= 1'b0;
      r_committed <= 1'b0;
    end else begin
      r_committed <= w_frame_end && r_pend_vld;
      if (w_frame_end && r_pend_vld) begin
        r_disp     <= r_pend;
        r_disp_dp  <= r_pend_dp;
        r_pend_vld <= 1'b0;
      end
      if (load) begin
        r_pend     <= data;
        r_pend_dp  <= dp_mask;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .i_nib (w_nib),
    .o_seg (w_font)
  );

  // w_zero_from[k] is set when nibbles k..7 of the display word are all zero.
  always_comb begin
    logic acc;
    acc         = 1'b1;
    w_zero_from = '0;
    for (int k = 7; k >= 0; k--) begin
      acc            = acc && (r_disp[4*k +: 4] == 4'd0);
      w_zero_from[k] = acc;
    end
  end

  assign w_blank = blank_en && (r_idx != 3'd0) && w_zero_from[r_idx];

  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_an_nxt  = AN_OFF;
    if (r_presc >= GUARD_V) begin
      w_an_nxt = ~(8'd1 << r_idx);
      if (!w_blank) begin
        w_seg_nxt = {~r_disp_dp[r_idx], w_font};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign SEG       = r_seg;
  assign AN        = r_an;
  assign committed = r_committed;
  assign frame     = w_frame_end;

endmodule
